// File: rtl/ari_shift_if.sv
// Operand/result handshake bundle for ari_shift_pipe.
// master = operand source + result consumer, slave = the shifter.
interface ari_shift_if #(
   parameter int WIDTH = 16
);
   localparam int AW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AW-1:0]    in_amt;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;

   modport master (
      output in_valid, in_data, in_amt, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_carry
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, out_ready,
      output in_ready, out_valid, out_data, out_carry
   );
endinterface

// File: rtl/ari_shift_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROL/ROR, pass-through) with valid/ready on both sides.
// Define ARI_SHIFT_CARRY_EN to generate out_carry; otherwise out_carry is tied to 0.
module ari_shift_pipe #(
   parameter int WIDTH = 16,
   localparam int AW = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   ari_shift_if.slave bus
);
   localparam logic [2:0] OP_LSL = 3'b000;
   localparam logic [2:0] OP_LSR = 3'b001;
   localparam logic [2:0] OP_ASR = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   function automatic logic is_left(input logic [2:0] op);
      return (op == OP_LSL) || (op == OP_ROL);
   endfunction

   function automatic logic is_pass(input logic [2:0] op);
      return op > OP_ROR;
   endfunction

   function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      r = {<<{x}};
      return r;
   endfunction

   // Right shift by sh; left ops arrive bit-reversed so they reduce to LSR/ROR here.
   function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] x, input int sh,
                                            input logic [2:0] op);
      logic [WIDTH-1:0] fill;
      fill = '0;
      if (op == OP_ROL || op == OP_ROR)
         fill = x << (WIDTH - sh);
      else if (op == OP_ASR && x[WIDTH-1])
         fill = ~({WIDTH{1'b1}} >> sh);
      return (x >> sh) | fill;
   endfunction

`ifdef ARI_SHIFT_CARRY_EN
   function automatic logic carry0(input logic [WIDTH-1:0] x, input logic [AW-1:0] amt,
                                   input logic [2:0] op);
      logic [AW-1:0] lidx;
      logic [AW-1:0] ridx;
      lidx = -amt;
      ridx = amt - AW'(1);
      if (amt == '0 || is_pass(op))
         return 1'b0;
      return is_left(op) ? x[lidx] : x[ridx];
   endfunction
`endif

   logic in_rdy;

   for (genvar k = 0; k < AW; k++) begin : stg
      logic             vld;
      logic             vin;
      logic             mv;
      logic             ld;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] din;
      logic [WIDTH-1:0] dnx;
      logic [2:0]       opin;
      logic [AW-1:k]    amtin;
`ifdef ARI_SHIFT_CARRY_EN
      logic             cy;
      logic             cyin;
`endif

      // ---- stage k input: operand port for k = 0, previous stage otherwise ----
      if (k == 0) begin : g_src
         assign vin   = bus.in_valid && in_rdy;
         assign din   = is_left(bus.in_op) ? rev(bus.in_data) : bus.in_data;
         assign opin  = bus.in_op;
         assign amtin = bus.in_amt;
`ifdef ARI_SHIFT_CARRY_EN
         assign cyin  = carry0(bus.in_data, bus.in_amt, bus.in_op);
`endif
      end else begin : g_src
         assign vin   = stg[k-1].vld;
         assign din   = stg[k-1].q;
         assign opin  = stg[k-1].g_reg.op;
         assign amtin = stg[k-1].g_reg.amt;
`ifdef ARI_SHIFT_CARRY_EN
         assign cyin  = stg[k-1].cy;
`endif
      end

      // A stage takes new contents when empty or when its current contents move on.
      if (k == AW-1) begin : g_ctl
         assign mv = vld && bus.out_ready;
      end else begin : g_ctl
         assign mv = vld && stg[k+1].ld;
      end
      assign ld = !vld || mv;

      always_comb begin
         dnx = din;
         if (amtin[k] && !is_pass(opin))
            dnx = shr(din, 1 << k, opin);
         if (k == AW-1 && is_left(opin))
            dnx = rev(dnx);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            vld <= 1'b0;
         else if (flush)
            vld <= 1'b0;
         else if (ld)
            vld <= vin;
      end

      // ---- stage k register: final stage is the visible result and is reset ----
      if (k == AW-1) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q  <= '0;
`ifdef ARI_SHIFT_CARRY_EN
               cy <= 1'b0;
`endif
            end else if (ld && vin) begin
               q  <= dnx;
`ifdef ARI_SHIFT_CARRY_EN
               cy <= cyin;
`endif
            end
         end
      end else begin : g_reg
         logic [2:0]      op;
         logic [AW-1:k+1] amt;
         always_ff @(posedge clk) begin
            if (ld && vin) begin
               q   <= dnx;
               op  <= opin;
               amt <= amtin[AW-1:k+1];
`ifdef ARI_SHIFT_CARRY_EN
               cy  <= cyin;
`endif
            end
         end
      end
   end

   assign in_rdy        = stg[0].ld && !flush;
   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = stg[AW-1].vld;
   assign bus.out_data  = stg[AW-1].q;
`ifdef ARI_SHIFT_CARRY_EN
   assign bus.out_carry = stg[AW-1].cy;
`else
   assign bus.out_carry = 1'b0;
`endif
endmodule

// File: tb/tb_ari_shift_pipe.sv
// Directed bench for ari_shift_pipe at WIDTH=16: shifts, latency, backpressure, flush, reset.
module tb_ari_shift_pipe;
   localparam int WIDTH = 16;
   localparam logic [2:0] OP_LSL = 3'b000;
   localparam logic [2:0] OP_LSR = 3'b001;
   localparam logic [2:0] OP_ASR = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;
   localparam logic [2:0] OP_PAS = 3'b101;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ari_shift_if #(.WIDTH(WIDTH)) bus ();

   ari_shift_pipe #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(flush),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic cexp(input logic c);
`ifdef ARI_SHIFT_CARRY_EN
      return c;
`else
      return c & 1'b0;
`endif
   endfunction

   task automatic drive(input logic [15:0] d, input logic [3:0] a, input logic [2:0] op);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_amt   = a;
      bus.in_op    = op;
   endtask

   // One op on an idle pipe: result must appear on the 4th edge counting the accept edge.
   task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] a,
                         input logic [2:0] op, input logic [15:0] ed, input logic ec);
      @(negedge clk);
      drive(d, a, op);
      #1 chk({tag, "_in_ready"}, bus.in_ready, 1);
      @(posedge clk);
      for (int e = 1; e < 4; e++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk({tag, "_early_valid"}, bus.out_valid, 0);
         @(posedge clk);
      end
      @(negedge clk);
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_data"}, bus.out_data, ed);
      chk({tag, "_carry"}, bus.out_carry, cexp(ec));
   endtask

   initial begin
      int       sent;
      int       rcv;
      logic     tx_in;
      logic     first;
      logic     seen;
      logic [15:0] e;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_amt    = '0;
      bus.in_op     = '0;
      bus.out_ready = 1'b1;

      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_carry", bus.out_carry, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rel_in_ready", bus.in_ready, 1);

      run_op("lsl1",   16'h8001, 4'd1,  OP_LSL, 16'h0002, 1'b1);
      run_op("asr15",  16'h8000, 4'd15, OP_ASR, 16'hFFFF, 1'b0);
      run_op("lsr15",  16'h8000, 4'd15, OP_LSR, 16'h0001, 1'b0);
      run_op("rol1",   16'h8001, 4'd1,  OP_ROL, 16'h0003, 1'b1);
      run_op("ror4",   16'h0001, 4'd4,  OP_ROR, 16'h1000, 1'b0);
      run_op("pass",   16'h1234, 4'd7,  OP_PAS, 16'h1234, 1'b0);
      run_op("lsl0",   16'h00F0, 4'd0,  OP_LSL, 16'h00F0, 1'b0);
      run_op("lsr4",   16'h00FF, 4'd4,  OP_LSR, 16'h000F, 1'b1);
      run_op("rol4",   16'h1234, 4'd4,  OP_ROL, 16'h2341, 1'b1);
      run_op("ror8",   16'h1234, 4'd8,  OP_ROR, 16'h3412, 1'b0);
      run_op("asr3",   16'hC005, 4'd3,  OP_ASR, 16'hF800, 1'b1);

      // Backpressure: stream 8 ops with the consumer stalled for 10 cycles.
      sent = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
         if (cyc >= 4) begin
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_data", bus.out_data, 16'h8000);
         end
         if (sent < 8) drive(16'h8000, 4'(sent), OP_LSR);
         else bus.in_valid = 1'b0;
         #1 tx_in = bus.in_valid && bus.in_ready;
         @(posedge clk);
         if (tx_in) sent++;
      end
      chk("bp_accepts_before_stall", sent, 4);
      @(negedge clk);
      chk("bp_in_ready_low", bus.in_ready, 0);

      rcv   = 0;
      first = 1'b1;
      for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
         if (cyc > 0) @(negedge clk);
         bus.out_ready = 1'b1;
         if (sent < 8) drive(16'h8000, 4'(sent), OP_LSR);
         else bus.in_valid = 1'b0;
         #1;
         if (first) begin
            chk("bp_full_in_ready", bus.in_ready, 1);
            first = 1'b0;
         end
         tx_in = bus.in_valid && bus.in_ready;
         if (bus.out_valid) begin
            e = 16'h8000 >> rcv;
            chk("bp_order", bus.out_data, e);
            rcv++;
         end
         @(posedge clk);
         if (tx_in) sent++;
      end
      chk("bp_sent", sent, 8);
      chk("bp_received", rcv, 8);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_no_duplicate", bus.out_valid, 0);

      // Flush with a full pipe and a concurrent input.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(16'h00F0, 4'(i), OP_LSL);
         @(posedge clk);
      end
      @(negedge clk);
      chk("fl_pre_valid", bus.out_valid, 1);
      flush = 1'b1;
      drive(16'hABCD, 4'd0, OP_PAS);
      #1 chk("fl_in_ready", bus.in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_out_valid", bus.out_valid, 0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      chk("fl_no_emit", seen, 0);
      run_op("fl_after", 16'h0F00, 4'd4, OP_LSR, 16'h00F0, 1'b0);

      // Asynchronous reset in the middle of a stalled stream.
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(16'h0F0F, 4'(i + 1), OP_ROR);
         @(posedge clk);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rs_pre_valid", bus.out_valid, 1);
      chk("rs_pre_data", bus.out_data, 16'h8787);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_async_valid", bus.out_valid, 0);
      chk("rs_async_data", bus.out_data, 0);
      chk("rs_async_carry", bus.out_carry, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      #1 chk("rs_in_ready", bus.in_ready, 1);
      run_op("rs_after", 16'h0001, 4'd15, OP_LSL, 16'h8000, 1'b0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("rs_no_stale", seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
